// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the IF stage: reset/NOP defaults, widths,
// the fetch FSM state type and the fetch-queue entry layout.
package fetch_unit_pkg;

  localparam int          INSTR_W       = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: synchronous FIFO with push/pop/flush. A pop is honoured only
// when not empty; a push at full is honoured when a pop happens in the same
// cycle. Flush empties the FIFO and overrides push/pop.
module fetch_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DATA_W-1:0]      head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Pointer and occupancy update; flush has priority over push and pop.
  always_comb begin
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are not reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !(pop && !empty)));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Owns the PC, issues in-order instruction memory
// requests, buffers returned words and presents one {pc, instr} per cycle to
// IF/ID. Redirects flush the queue and discard responses still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          FQ_DEPTH  = 4,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_empty_cyc
`endif
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  // Outstanding includes stale requests, which are not bounded by the queue
  // depth, so the counter gets headroom and issue stops at its ceiling.
  localparam int              OUT_W   = $clog2(FQ_DEPTH) + 5;
  localparam logic [OUT_W-1:0] OUT_MAX = '1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] kill_cnt_q, kill_cnt_d;
  logic [OUT_W-1:0] kill_on_redirect;

  logic             req_fire, rsp_fire, rsp_keep;
  logic [SUM_W-1:0] occ_sum;

  logic             dq_pop, dq_full, dq_empty;
  logic [CNT_W-1:0] dq_count;
  fetch_entry_t     dq_head, dq_in;

  logic             tag_full, tag_empty;
  logic [CNT_W-1:0] tag_count;
  logic [31:0]      tag_head;

  // Issue decision: live words (queued + live outstanding) must fit the queue.
  always_comb begin
    occ_sum        = {1'b0, dq_count} + {1'b0, tag_count};
    imem_req_valid = !rst && !redirect_valid &&
                     (occ_sum < SUM_W'(FQ_DEPTH)) && (outstanding_q != OUT_MAX);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && (outstanding_q != '0);
    rsp_keep       = rsp_fire && !redirect_valid && (state_q == ST_RUN);
  end

  // PC advance and outstanding-request bookkeeping.
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    outstanding_d    = outstanding_q + OUT_W'(req_fire) - OUT_W'(rsp_fire);
    kill_on_redirect = outstanding_q - OUT_W'(rsp_fire);
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  // Next-state logic: DRAIN while stale responses remain to be discarded.
  always_comb begin
    state_d    = state_q;
    kill_cnt_d = kill_cnt_q;
    if (redirect_valid) begin
      kill_cnt_d = kill_on_redirect;
      state_d    = (kill_on_redirect != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          kill_cnt_d = '0;
        end
        ST_DRAIN: begin
          if (rsp_fire) begin
            kill_cnt_d = kill_cnt_q - 1'b1;
            if (kill_cnt_q == OUT_W'(1)) state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= align_pc(RESET_PC);
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
    end
  end

  // Tag FIFO holds the pc of each live outstanding request, in issue order;
  // stale tags are flushed on redirect so it never exceeds FQ_DEPTH.
  fetch_queue #(
    .DATA_W (32),
    .DEPTH  (FQ_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head_data (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  assign dq_in  = '{pc: tag_head, instr: imem_rsp_data};
  assign dq_pop = fetch_valid && !stall;

  // Data queue: head entry drives the IF/ID outputs directly.
  fetch_queue #(
    .DATA_W (64),
    .DEPTH  (FQ_DEPTH)
  ) u_data_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (dq_in),
    .pop       (dq_pop),
    .flush     (redirect_valid),
    .head_data (dq_head),
    .full      (dq_full),
    .empty     (dq_empty),
    .count     (dq_count)
  );

  assign fetch_valid = !dq_empty;
  assign pc_out      = fetch_valid ? dq_head.pc    : 32'h0;
  assign instr_out   = fetch_valid ? dq_head.instr : NOP_INSTR;

  drain_state_chk: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_DRAIN) == (kill_cnt_q != '0));
  tag_push_chk: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && tag_full));
  tag_pop_chk: assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && tag_empty));
  data_push_chk: assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && dq_full && !dq_pop));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_empty_q, perf_empty_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Saturating event counters.
  always_comb begin
    perf_stall_d = sat_inc(perf_stall_q, fetch_valid && stall);
    perf_flush_d = sat_inc(perf_flush_q, redirect_valid);
    perf_empty_d = sat_inc(perf_empty_q, !fetch_valid);
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_empty_q <= perf_empty_d;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_empty_cyc = perf_empty_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency, and a
// golden PC-sequence scoreboard (PC restarts at each redirect target).
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] pc_out, instr_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_empty_cyc;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .FQ_DEPTH  (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .pc_out         (pc_out),
    .instr_out      (instr_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_empty_cyc (perf_empty_cyc)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc;
  int          live;
  int          dly_max;
  int          first_fv_cyc;
  int          npops;
  logic [31:0] exp_pc, exp_addr;
  logic [31:0] mq_addr[$];
  int          mq_rdy[$];
  logic [31:0] acc_log[$];
  logic        prev_hold;
  logic [31:0] prev_pc, prev_instr;
  logic        last_fv, last_req_valid;
  logic [31:0] last_pc;
  int unsigned c_stall, c_flush, c_empty;

  function automatic logic [31:0] mk_instr(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0001;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || pc_out !== 32'h0 || instr_out !== NOP) begin
      bad++;
      $display("FAIL reset_state: got rv=%b fv=%b pc=%h instr=%h required rv=0 fv=0 pc=0 instr=%h",
               imem_req_valid, fetch_valid, pc_out, instr_out, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (perf_stall_cyc !== 0 || perf_flush_cnt !== 0 || perf_empty_cyc !== 0) begin
      bad++;
      $display("FAIL reset_perf: got %0d %0d %0d required 0 0 0", perf_stall_cyc, perf_flush_cnt, perf_empty_cyc);
    end
`endif
    rst = 1'b0;
    mq_addr.delete(); mq_rdy.delete(); acc_log.delete();
    exp_pc = RST_PC; exp_addr = RST_PC; live = 0; cyc = 1;
    prev_hold = 1'b0; first_fv_cyc = 0;
    c_stall = 0; c_flush = 0; c_empty = 0;
  endtask

  // One clock cycle: drive inputs, sample outputs well before the edge,
  // check against the model, then advance to the next falling edge.
  task automatic do_cycle(input logic st, input logic rd, input logic [31:0] rpc,
                          input int rdy_pct, input int rsp_pct);
    logic acc, popv;
    stall = st; redirect_valid = rd; redirect_pc = rpc;
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mq_addr.size() > 0 && mq_rdy[0] <= cyc && $urandom_range(0, 99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mk_instr(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_rdy.pop_front());
    end
    #1;
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (perf_stall_cyc !== c_stall || perf_flush_cnt !== c_flush || perf_empty_cyc !== c_empty) begin
      bad++;
      $display("FAIL perf_cnt: got %0d %0d %0d required %0d %0d %0d", perf_stall_cyc,
               perf_flush_cnt, perf_empty_cyc, c_stall, c_flush, c_empty);
    end
`endif
    total++;
    if (imem_req_valid !== (!rd && live < DEPTH)) begin
      bad++;
      $display("FAIL issue_rule: got req_valid=%b required %b (live=%0d rd=%b)",
               imem_req_valid, (!rd && live < DEPTH), live, rd);
    end
    if (!fetch_valid) begin
      total++;
      if (instr_out !== NOP) begin
        bad++;
        $display("FAIL nop_out: got %h required %h", instr_out, NOP);
      end
    end
    if (prev_hold) begin
      total++;
      if (fetch_valid !== 1'b1 || pc_out !== prev_pc || instr_out !== prev_instr) begin
        bad++;
        $display("FAIL stall_hold: got fv=%b pc=%h instr=%h required fv=1 pc=%h instr=%h",
                 fetch_valid, pc_out, instr_out, prev_pc, prev_instr);
      end
    end
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      total++;
      if (imem_req_addr !== exp_addr) begin
        bad++;
        $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_addr);
      end
      mq_addr.push_back(imem_req_addr);
      mq_rdy.push_back(cyc + 1 + int'($urandom_range(0, dly_max)));
      acc_log.push_back(imem_req_addr);
      exp_addr = exp_addr + 32'd4;
      live++;
    end
    popv = fetch_valid && !st && !rd;
    if (popv) begin
      total++;
      if (pc_out !== exp_pc || instr_out !== mk_instr(exp_pc)) begin
        bad++;
        $display("FAIL fetch_out: got pc=%h instr=%h required pc=%h instr=%h",
                 pc_out, instr_out, exp_pc, mk_instr(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      live--;
      npops++;
    end
    if (fetch_valid && first_fv_cyc == 0) first_fv_cyc = cyc;
    if (fetch_valid && st) c_stall++;
    if (rd) c_flush++;
    if (!fetch_valid) c_empty++;
    if (rd) begin
      exp_pc   = {rpc[31:2], 2'b00};
      exp_addr = {rpc[31:2], 2'b00};
      live     = 0;
      acc_log.delete();
    end
    prev_hold      = fetch_valid && st && !rd;
    prev_pc        = pc_out;
    prev_instr     = instr_out;
    last_fv        = fetch_valid;
    last_pc        = pc_out;
    last_req_valid = imem_req_valid;
    @(negedge clk);
    cyc++;
  endtask

  // Runs until a valid output is presented, then checks its pc.
  task automatic expect_first_pc(input logic [31:0] want, input logic st);
    int n = 0;
    while (!last_fv && n < 30) begin
      do_cycle(st, 1'b0, 32'h0, 100, 100);
      n++;
    end
    total++;
    if (!last_fv || last_pc !== want) begin
      bad++;
      $display("FAIL first_pc_after_redirect: got fv=%b pc=%h required fv=1 pc=%h", last_fv, last_pc, want);
    end
  endtask

  task automatic test_reset();
    reset_dut();
  endtask

  task automatic test_stream();
    reset_dut();
    dly_max = 0;
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
    total++;
    if (first_fv_cyc != 3) begin
      bad++;
      $display("FAIL first_valid_cycle: got %0d required 3", first_fv_cyc);
    end
    total++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
      bad++;
      $display("FAIL addr_stream: got size=%0d required 0,4,8 first", acc_log.size());
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 32'h0, 100, 100);
    total++;
    if (last_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_backpressure: got req_valid=%b required 0", last_req_valid);
    end
    for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
  endtask

  task automatic test_redirect_drain();
    reset_dut();
    dly_max = 0;
    do_cycle(1'b0, 1'b0, 32'h0, 100, 0);
    do_cycle(1'b0, 1'b0, 32'h0, 100, 0);
    do_cycle(1'b0, 1'b1, 32'h100, 100, 0);
    do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
    total++;
    if (last_fv !== 1'b0) begin
      bad++;
      $display("FAIL nop_after_redirect: got fv=%b required 0", last_fv);
    end
    expect_first_pc(32'h100, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
  endtask

  task automatic test_redirect_stall_rsp();
    reset_dut();
    dly_max = 0;
    do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
    do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
    do_cycle(1'b1, 1'b0, 32'h0, 100, 0);
    do_cycle(1'b1, 1'b1, 32'h200, 100, 100);
    do_cycle(1'b1, 1'b0, 32'h0, 100, 100);
    total++;
    if (last_fv !== 1'b0) begin
      bad++;
      $display("FAIL flush_over_stall: got fv=%b required 0", last_fv);
    end
    expect_first_pc(32'h200, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
  endtask

  task automatic test_wrap_align();
    int n;
    do_cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 100, 100);
    n = 0;
    while (acc_log.size() < 2 && n < 20) begin
      do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
      n++;
    end
    total++;
    if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
      bad++;
      $display("FAIL pc_wrap: got size=%0d required FFFFFFFC then 00000000", acc_log.size());
    end
    expect_first_pc(32'hFFFF_FFFC, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h103, 100, 100);
    n = 0;
    while (acc_log.size() < 1 && n < 20) begin
      do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
      n++;
    end
    total++;
    if (acc_log.size() < 1 || acc_log[0] !== 32'h100) begin
      bad++;
      $display("FAIL redirect_align: got size=%0d required first addr 00000100", acc_log.size());
    end
    expect_first_pc(32'h100, 1'b0);
  endtask

  task automatic test_random();
    logic st, rd;
    reset_dut();
    dly_max = 3;
    npops = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) reset_dut();
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 3);
      do_cycle(st, rd, $urandom, 60, 70);
    end
    for (int i = 0; i < 30; i++) do_cycle(1'b0, 1'b0, 32'h0, 100, 100);
    total++;
    if (npops < 200) begin
      bad++;
      $display("FAIL random_progress: got %0d pops required >= 200", npops);
    end
  endtask

  initial begin
    npops = 0;
    dly_max = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_stall_rsp();
    test_wrap_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
